// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard for the ID stage.
// Define REGFILE_BYPASS_EN for write-through reads (WB data and busy release in the retire cycle).
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_rd,
    output logic              o_issue_full,
    input  logic              i_wb_valid,
    input  logic              i_wb_wren,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt [DEPTH];

    logic wr_en;
    logic issue_fire;
    logic retire_fire;

    assign wr_en        = i_wb_valid & i_wb_wren & (i_wb_rd != '0);
    assign retire_fire  = i_wb_valid & (i_wb_rd != '0);
    assign o_issue_full = (i_issue_rd != '0) && (cnt[i_issue_rd] == CNT_MAX);
    assign issue_fire   = i_issue_valid & (i_issue_rd != '0) & ~o_issue_full;

    // NOTE: the whole array is cleared on reset, so storage maps to flops rather than a RAM macro;
    // a zeroed register file is part of the reset contract here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mem[i_wb_rd] <= i_wb_data;
        end
    end

    // Entry 0 is only ever written by reset, so it stays at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                logic inc;
                logic dec;
                inc = issue_fire  && (i_issue_rd == ADDR_W'(i));
                dec = retire_fire && (i_wb_rd    == ADDR_W'(i));
                if (inc && !dec) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec && !inc && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    logic [DATA_W-1:0] rs1_mem;
    logic [DATA_W-1:0] rs2_mem;
    logic              rs1_pend;
    logic              rs2_pend;

    assign rs1_mem  = (i_rs1_addr == '0) ? '0 : mem[i_rs1_addr];
    assign rs2_mem  = (i_rs2_addr == '0) ? '0 : mem[i_rs2_addr];
    assign rs1_pend = (cnt[i_rs1_addr] != '0);
    assign rs2_pend = (cnt[i_rs2_addr] != '0);

`ifdef REGFILE_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = wr_en && (i_wb_rd == i_rs1_addr);
    assign rs2_hit = wr_en && (i_wb_rd == i_rs2_addr);

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        o_rs1_data = rs1_mem;
        o_rs2_data = rs2_mem;
        o_rs1_busy = rs1_pend;
        o_rs2_busy = rs2_pend;
        // The retiring write is the last pending one when the counter is exactly 1.
        if (rs1_hit) begin
            o_rs1_data = i_wb_data;
            o_rs1_busy = (cnt[i_rs1_addr] > CNT_ONE);
        end
        if (rs2_hit) begin
            o_rs2_data = i_wb_data;
            o_rs2_busy = (cnt[i_rs2_addr] > CNT_ONE);
        end
    end
`else
    always_comb begin
        o_rs1_data = rs1_mem;
        o_rs2_data = rs2_mem;
        o_rs1_busy = rs1_pend;
        o_rs2_busy = rs2_pend;
    end
`endif

    // Retiring a register with no pending write means the pipeline lost track of an instruction.
    assert property (@(posedge i_clk) disable iff (i_rst)
        retire_fire |-> (cnt[i_wb_rd] != '0))
    else $error("regfile_sb: retire to x%0d with no pending write", i_wb_rd);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [ADDR_W-1:0] i_rs1_addr = '0;
    logic [ADDR_W-1:0] i_rs2_addr = '0;
    logic [DATA_W-1:0] o_rs1_data;
    logic [DATA_W-1:0] o_rs2_data;
    logic              o_rs1_busy;
    logic              o_rs2_busy;
    logic              i_issue_valid = 1'b0;
    logic [ADDR_W-1:0] i_issue_rd = '0;
    logic              o_issue_full;
    logic              i_wb_valid = 1'b0;
    logic              i_wb_wren = 1'b0;
    logic [ADDR_W-1:0] i_wb_rd = '0;
    logic [DATA_W-1:0] i_wb_data = '0;

    int errors = 0;
    int checks = 0;

    // Reference model: plain values and pending-write counts.
    int unsigned m_mem [DEPTH];
    int          m_cnt [DEPTH];

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_issue_full(o_issue_full),
        .i_wb_valid(i_wb_valid), .i_wb_wren(i_wb_wren), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 0;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic logic wb_hits(input int a);
`ifdef REGFILE_BYPASS_EN
        return i_wb_valid && i_wb_wren && (a != 0) && (int'(i_wb_rd) == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (wb_hits(a)) return i_wb_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (wb_hits(a)) return m_cnt[a] > 1;
        return m_cnt[a] != 0;
    endfunction

    function automatic logic exp_full();
        return (i_issue_rd != '0) && (m_cnt[i_issue_rd] == MAXC);
    endfunction

    // Issue is accounted first, then retire, clamped at zero.
    function automatic void model_commit();
        int rd;
        int wr;
        rd = int'(i_issue_rd);
        wr = int'(i_wb_rd);
        if (i_wb_valid && i_wb_wren && wr != 0) m_mem[wr] = i_wb_data;
        if (i_issue_valid && rd != 0 && m_cnt[rd] < MAXC) m_cnt[rd] = m_cnt[rd] + 1;
        if (i_wb_valid && wr != 0 && m_cnt[wr] > 0) m_cnt[wr] = m_cnt[wr] - 1;
    endfunction

    task automatic cycle();
        @(posedge i_clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        i_issue_valid = 1'b0;
        i_issue_rd    = '0;
        i_wb_valid    = 1'b0;
        i_wb_wren     = 1'b0;
        i_wb_rd       = '0;
        i_wb_data     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1'b1;
        model_reset();
        #12;
        i_rst = 1'b0;
        @(negedge i_clk);
        for (int a = 0; a < DEPTH; a++) begin
            i_rs1_addr = ADDR_W'(a);
            i_rs2_addr = ADDR_W'(DEPTH - 1 - a);
            i_issue_rd = ADDR_W'(a);
            #1;
            checks++;
            if (o_rs1_data !== '0 || o_rs2_data !== '0 || o_rs1_busy !== 1'b0 ||
                o_rs2_busy !== 1'b0 || o_issue_full !== 1'b0) begin
                errors++;
                $display("FAIL reset_state addr=%0d got data=%h/%h busy=%b/%b full=%b want all 0",
                         a, o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_full);
            end
        end
        i_issue_rd = '0;
        i_wb_valid = 1'b1;
        i_wb_wren  = 1'b1;
        i_wb_rd    = '0;
        i_wb_data  = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        i_rs1_addr = '0;
        #1;
        checks++;
        if (o_rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_write got %h want 00000000", o_rs1_data);
        end
    endtask

    task automatic test_issue_retire();
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd5;
        cycle();
        idle_inputs();
        i_rs1_addr = 5'd5;
        #1;
        checks++;
        if (o_rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_busy got %b want 1", o_rs1_busy);
        end
        i_wb_valid = 1'b1;
        i_wb_wren  = 1'b1;
        i_wb_rd    = 5'd5;
        i_wb_data  = 32'h12345678;
        #1;
        checks++;
        if (o_rs1_data !== exp_data(5) || o_rs1_busy !== exp_busy(5)) begin
            errors++;
            $display("FAIL retire_cycle got data=%h busy=%b want data=%h busy=%b",
                     o_rs1_data, o_rs1_busy, exp_data(5), exp_busy(5));
        end
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (o_rs1_data !== 32'h12345678 || o_rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_retire got data=%h busy=%b want 12345678 busy=0",
                     o_rs1_data, o_rs1_busy);
        end
    endtask

    task automatic test_saturation();
        i_rs1_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            i_issue_valid = 1'b1;
            i_issue_rd    = 5'd7;
            cycle();
        end
        i_issue_valid = 1'b0;
        #1;
        checks++;
        if (o_issue_full !== 1'b1) begin
            errors++;
            $display("FAIL full_after_3 got %b want 1", o_issue_full);
        end
        i_issue_valid = 1'b1;
        cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            i_wb_valid = 1'b1;
            i_wb_wren  = 1'b1;
            i_wb_rd    = 5'd7;
            i_wb_data  = 32'hA0 + k;
            cycle();
            idle_inputs();
            #1;
            checks++;
            if (o_rs1_busy !== (k < 2) || o_rs1_data !== 32'hA0 + k) begin
                errors++;
                $display("FAIL sat_retire_%0d got busy=%b data=%h want busy=%b data=%h",
                         k, o_rs1_busy, o_rs1_data, (k < 2), 32'hA0 + k);
            end
        end
    endtask

    task automatic test_same_cycle();
        i_rs1_addr    = 5'd9;
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd9;
        cycle();
        i_wb_valid = 1'b1;
        i_wb_wren  = 1'b1;
        i_wb_rd    = 5'd9;
        i_wb_data  = 32'hCAFE0009;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (o_rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_busy got %b want 1", o_rs1_busy);
        end
        i_wb_valid = 1'b1;
        i_wb_wren  = 1'b0;
        i_wb_rd    = 5'd9;
        i_wb_data  = 32'hFFFFFFFF;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (o_rs1_busy !== 1'b0 || o_rs1_data !== 32'hCAFE0009) begin
            errors++;
            $display("FAIL squash got busy=%b data=%h want busy=0 data=cafe0009",
                     o_rs1_busy, o_rs1_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int wr;
            i_rs1_addr    = ADDR_W'($urandom_range(0, 7));
            i_rs2_addr    = ADDR_W'($urandom_range(0, 7));
            i_issue_valid = 1'($urandom_range(0, 1));
            i_issue_rd    = ADDR_W'($urandom_range(0, 7));
            wr            = $urandom_range(0, 7);
            // Retire only registers with a pending write (x0 is always legal).
            i_wb_valid    = (wr == 0 || m_cnt[wr] > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_wb_wren     = 1'($urandom_range(0, 3) != 0);
            i_wb_rd       = ADDR_W'(wr);
            i_wb_data     = $urandom;
            #1;
            checks++;
            if (o_rs1_data !== exp_data(int'(i_rs1_addr)) || o_rs2_data !== exp_data(int'(i_rs2_addr)) ||
                o_rs1_busy !== exp_busy(int'(i_rs1_addr)) || o_rs2_busy !== exp_busy(int'(i_rs2_addr)) ||
                o_issue_full !== exp_full()) begin
                errors++;
                $display("FAIL random_%0d got %h/%h busy=%b/%b full=%b want %h/%h busy=%b/%b full=%b",
                         n, o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_full,
                         exp_data(int'(i_rs1_addr)), exp_data(int'(i_rs2_addr)),
                         exp_busy(int'(i_rs1_addr)), exp_busy(int'(i_rs2_addr)), exp_full());
            end
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd4;
        cycle();
        i_issue_rd    = 5'd6;
        cycle();
        idle_inputs();
        i_rs1_addr = 5'd4;
        i_rs2_addr = 5'd6;
        #1;
        checks++;
        if (o_rs1_busy !== 1'b1 || o_rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got %b/%b want 1/1", o_rs1_busy, o_rs2_busy);
        end
        #1;
        i_rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy got %b/%b want 0/0", o_rs1_busy, o_rs2_busy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            i_rs1_addr = ADDR_W'(a);
            #1;
            checks++;
            if (o_rs1_data !== '0) begin
                errors++;
                $display("FAIL async_reset_data x%0d got %h want 0", a, o_rs1_data);
            end
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_rs1_addr = 5'd5;
        #1;
        checks++;
        if (o_rs1_data !== '0 || o_rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got data=%h busy=%b want 0/0", o_rs1_data, o_rs1_busy);
        end
    endtask

    initial begin
        test_reset();
        test_issue_retire();
        test_saturation();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard, for the ID stage of the non-forwarding pipeline. It provides two asynchronous read ports and one synchronous write port, with entry 0 hardwired to zero. It tracks in-flight writes per destination register so that ID can stall on RAW hazards without external hazard logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- CNT_W, 2, scoreboard counter width; up to 2**CNT_W-1 in-flight writes per register
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_rs1_addr  in  ADDR_W  read port 1 address
- i_rs2_addr  in  ADDR_W  read port 2 address
- o_rs1_data  out  DATA_W  read port 1 data
- o_rs2_data  out  DATA_W  read port 2 data
- o_rs1_busy  out  1  rs1 has a pending write
- o_rs2_busy  out  1  rs2 has a pending write
- i_issue_valid  in  1  instruction leaves ID this cycle and will write i_issue_rd
- i_issue_rd  in  ADDR_W  destination of the issuing instruction
- o_issue_full  out  1  i_issue_rd counter saturated; ID must stall
- i_wb_valid  in  1  instruction retires at WB; counter for i_wb_rd decrements
- i_wb_wren  in  1  retiring instruction writes data (0 = squashed, scoreboard only)
- i_wb_rd  in  ADDR_W  write/retire address
- i_wb_data  in  DATA_W  write data

## Operation
- Storage: 2**ADDR_W x DATA_W. On a clock edge with i_wb_valid & i_wb_wren & i_wb_rd!=0, mem[i_wb_rd] <= i_wb_data.
- Reads are combinational: o_rsN_data = mem[i_rsN_addr]. Address 0 always returns 0.
- Scoreboard: one CNT_W-bit counter per entry. cnt[0] is constant 0 and is never incremented.
- On issue (i_issue_valid & i_issue_rd!=0 & !o_issue_full), cnt[i_issue_rd] increments.
- On retire (i_wb_valid & i_wb_rd!=0), cnt[i_wb_rd] decrements.
- Issue and retire to the same register in the same cycle: net 0, counter unchanged.
- Retire while the counter is 0 is a protocol error. The counter holds at 0 (no wrap). Simulation asserts.
- Issue while o_issue_full is ignored: the counter holds at its maximum and does not wrap.
- o_issue_full = (cnt[i_issue_rd] == 2**CNT_W-1) & i_issue_rd!=0. It is combinational and is independent of the same-cycle retire.
- o_rsN_busy = cnt[i_rsN_addr]!=0, modified as described under Configuration. Address 0 is never busy.
- Reset: all counters go to 0 and all mem entries go to 0.

## Timing
- Read data and busy flags are combinational from address inputs and state, with zero latency.
- Writes and counter updates take effect on the rising edge. Without bypass, data is visible on the read port the cycle after the write.
- Reset is asynchronous. The reset values of all outputs follow from zeroed state: o_rsN_data=0, o_rsN_busy=0, o_issue_full=0.
- Reset asserted mid-operation drops every in-flight record. The pipeline must be flushed by the same reset.
- No output is registered. Combinational paths run from i_rs*_addr, i_issue_rd and i_wb_* to the outputs.

## Configuration
- REGFILE_BYPASS_EN defined: write-through behaviour.
  - If i_wb_valid & i_wb_wren & i_wb_rd==i_rsN_addr & i_rsN_addr!=0, then o_rsN_data = i_wb_data in the same cycle.
  - In that case, o_rsN_busy = (cnt[i_rsN_addr] > 1), so the last pending write is consumed as it retires.
- REGFILE_BYPASS_EN undefined:
  - o_rsN_data = mem[i_rsN_addr] only.
  - o_rsN_busy = cnt[i_rsN_addr]!=0, so a dependent instruction stalls one extra cycle until the counter clears.

## Test plan
- Reset then read all addresses -> all data 0, busy=0, o_issue_full=0. Write x0 with 0xDEADBEEF -> reading x0 still gives 0.
- Issue rd=5, then read rs1=5 -> o_rs1_busy=1. Retire with rd=5, data 0x12345678, then the next cycle -> busy=0, data 0x12345678. With the bypass macro, data and busy=0 appear in the retire cycle.
- Three issues to x7 with CNT_W=2 -> o_issue_full=1. A fourth issue is ignored. Three retires -> busy clears only after the third.
- Same-cycle issue and retire to x9 with counter 1 -> counter stays 1 and busy stays 1. Squashed retire (i_wb_wren=0) to x9 -> counter 0, and the stored data is unchanged.
- Retire to x3 with the counter at 0 -> the counter stays 0 and the assertion fires in simulation.
- Assert i_rst asynchronously between clock edges with counters nonzero -> busy drops immediately and all data reads 0.
